instr_register_param: RTL and testbench
=======================================

// Module: instr_register_param
// PURPOSE
//   Parametrised instruction register file: stores {opcode, op_a, op_b, result} per entry.
//   Result is computed at write time. Adds per-entry valid bits, an occupancy count,
//   registered reads with a valid strobe, a sync clear and an error flag per entry.
//   Sits between the stimulus/decode front end and the result checker.
// PARAMETERS
//   DEPTH   32  number of entries; need not be a power of 2
//   OP_W    32  signed operand width
//   OPC_W   4   opcode width; codes 0..7 defined, 8..2^OPC_W-1 illegal
//   localparam PTR_W = $clog2(DEPTH), RES_W = 2*OP_W (derived, not overridable)
// PORTS
//   clk            in   1      clock; all state changes on posedge
//   reset_n        in   1      async reset, active low
//   clr            in   1      sync clear of all valid bits
//   load_en        in   1      write strobe
//   write_pointer  in   PTR_W  write address
//   opcode         in   OPC_W  0 ZERO,1 PASSA,2 PASSB,3 ADD,4 SUB,5 MULT,6 DIV,7 MOD
//   operand_a      in   OP_W   signed operand A
//   operand_b      in   OP_W   signed operand B
//   rd_en          in   1      read request
//   read_pointer   in   PTR_W  read address
//   rd_valid       out  1      read data valid, one-cycle pulse
//   rd_opcode      out  OPC_W  stored opcode
//   rd_op_a        out  OP_W   stored operand A
//   rd_op_b        out  OP_W   stored operand B
//   rd_result      out  RES_W  stored signed result
//   rd_entry_vld   out  1      entry was written since reset/clr
//   rd_err         out  1      stored error flag (div/mod by zero, illegal opcode)
//   wr_count       out  PTR_W+1  number of valid entries
// BEHAVIOUR
// - Reset (reset_n low, async): every entry, valid bit and err bit = 0. All outputs = 0.
// - Write: posedge with load_en=1 and write_pointer<DEPTH -> entry <= {opcode,a,b,result,err}.
//   Valid bit is set. A pointer >=DEPTH is ignored: no state change.
// - Result: sign-extended to RES_W.
//   ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=full a*b.
//   DIV=a/b and MOD=a%b, truncating toward zero.
//   b==0 on DIV/MOD: result=0, err=1. Illegal opcode: result=0, err=1. Else err=0.
// - wr_count: +1 only when writing an entry whose valid bit is 0.
//   Overwrite of a valid entry leaves the count unchanged. Never exceeds DEPTH.
// - Read: rd_en at edge N -> rd_* registered and rd_valid=1 after edge N+1 (latency 1).
//   rd_valid=0 in any cycle with no request. rd_* hold their last value while rd_valid=0.
//   Back-to-back reads are allowed every cycle.
// - Read of an unwritten entry or read_pointer>=DEPTH: all rd_* data = 0, rd_entry_vld=0,
//   rd_valid=1.
// - clr: all valid bits and wr_count -> 0 at the edge. Entry data is retained but reads as 0.
//   clr + load_en in the same cycle: the clear applies first, then the write.
//   Result: the written entry is valid and wr_count=1.
//   clr + rd_en in the same cycle: the read returns pre-clear contents.
// - Same-cycle write and read of the same address: see CONFIGURATION.
// - reset_n asserted mid-read: rd_valid drops to 0 immediately. The pending read is lost.
// CONFIGURATION
//   INSTR_REG_BYPASS_EN defined: same-cycle write+read to the same valid address
//     returns the newly written data (write-first forwarding). rd_entry_vld=1.
//   INSTR_REG_BYPASS_EN undefined: the read returns the pre-write contents (read-first).
//     If the entry was previously unwritten, the read returns 0 with rd_entry_vld=0.
// TESTING
// 1. Reset with rd_en=1 -> all rd_*=0, rd_valid=0, wr_count=0.
//    After release, read addr 3 -> rd_valid=1, rd_entry_vld=0, rd_result=0.
// 2. Write addr0 ADD a=-7 b=5, addr1 MULT a=-3 b=4, addr2 SUB a=15 b=-15.
//    Read back 0..2 -> results -2, -12, 30, err=0, wr_count=3.
// 3. DIV a=-7 b=2 -> result -3. MOD a=-7 b=2 -> -1. DIV a=9 b=0 -> 0 with err=1.
//    Opcode 12 -> result 0, err=1.
// 4. Write addr5 twice, then read -> second data is returned, wr_count +1 only.
//    write_pointer=DEPTH -> wr_count unchanged.
// 5. clr together with a write to addr4 -> wr_count=1.
//    Read addr0 -> entry_vld=0. Read addr4 -> entry_vld=1.
// 6. Write addr7 ADD 1,1 and read addr7 in the same cycle.
//    With macro: rd_result=2. Without macro: rd_result=0, entry_vld=0.

Source files
------------

// File: rtl/instr_register_param.sv
// Instruction register file: {opcode, op_a, op_b, result, err} per entry, result computed at write time.
// Define INSTR_REG_BYPASS_EN for write-first forwarding on same-address write+read; default is read-first.
module instr_register_param #(
    parameter  int DEPTH = 32,
    parameter  int OP_W  = 32,
    parameter  int OPC_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int RES_W = 2 * OP_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load_en,
    input  logic [PTR_W-1:0] write_pointer,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OP_W-1:0]  operand_a,
    input  logic [OP_W-1:0]  operand_b,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] read_pointer,
    output logic             rd_valid,
    output logic [OPC_W-1:0] rd_opcode,
    output logic [OP_W-1:0]  rd_op_a,
    output logic [OP_W-1:0]  rd_op_b,
    output logic [RES_W-1:0] rd_result,
    output logic             rd_entry_vld,
    output logic             rd_err,
    output logic [PTR_W:0]   wr_count
);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C     = (PTR_W+1)'(1);
    localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_err;
    logic [OPC_W-1:0] r_opc [DEPTH];
    logic [OP_W-1:0]  r_a   [DEPTH];
    logic [OP_W-1:0]  r_b   [DEPTH];
    logic [RES_W-1:0] r_res [DEPTH];
    logic [PTR_W:0]   r_wr_count;

    logic             r_rd_valid;
    logic [OPC_W-1:0] r_rd_opc;
    logic [OP_W-1:0]  r_rd_a;
    logic [OP_W-1:0]  r_rd_b;
    logic [RES_W-1:0] r_rd_res;
    logic             r_rd_vld;
    logic             r_rd_err;

    logic                    w_wr_ok;
    logic                    w_rd_ok;
    logic signed [RES_W-1:0] w_a_ext;
    logic signed [RES_W-1:0] w_b_ext;
    logic [RES_W-1:0]        w_res;
    logic                    w_err;
    logic [OPC_W-1:0]        w_rd_opc;
    logic [OP_W-1:0]         w_rd_a;
    logic [OP_W-1:0]         w_rd_b;
    logic [RES_W-1:0]        w_rd_res;
    logic                    w_rd_vld;
    logic                    w_rd_err;

    assign w_wr_ok = load_en && ({1'b0, write_pointer} < DEPTH_C);
    assign w_rd_ok = {1'b0, read_pointer} < DEPTH_C;
    assign w_a_ext = {{OP_W{operand_a[OP_W-1]}}, operand_a};
    assign w_b_ext = {{OP_W{operand_b[OP_W-1]}}, operand_b};

    // Operands are widened to RES_W first so MULT is the full product and DIV cannot overflow.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (opcode)
            OPC_ZERO:  w_res = '0;
            OPC_PASSA: w_res = w_a_ext;
            OPC_PASSB: w_res = w_b_ext;
            OPC_ADD:   w_res = w_a_ext + w_b_ext;
            OPC_SUB:   w_res = w_a_ext - w_b_ext;
            OPC_MULT:  w_res = w_a_ext * w_b_ext;
            OPC_DIV: begin
                if (operand_b == '0) w_err = 1'b1;
                else                 w_res = w_a_ext / w_b_ext;
            end
            OPC_MOD: begin
                if (operand_b == '0) w_err = 1'b1;
                else                 w_res = w_a_ext % w_b_ext;
            end
            default:   w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld      <= '0;
            r_err      <= '0;
            r_wr_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_opc[i] <= '0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
        end else begin
            // Clear first; a same-cycle write then re-validates its own entry.
            if (clr) begin
                r_vld      <= '0;
                r_wr_count <= w_wr_ok ? ONE_C : '0;
            end else if (w_wr_ok && !r_vld[write_pointer]) begin
                r_wr_count <= r_wr_count + ONE_C;
            end
            if (w_wr_ok) begin
                r_vld[write_pointer] <= 1'b1;
                r_err[write_pointer] <= w_err;
                r_opc[write_pointer] <= opcode;
                r_a[write_pointer]   <= operand_a;
                r_b[write_pointer]   <= operand_b;
                r_res[write_pointer] <= w_res;
            end
        end
    end

    always_comb begin
        w_rd_opc = '0;
        w_rd_a   = '0;
        w_rd_b   = '0;
        w_rd_res = '0;
        w_rd_vld = 1'b0;
        w_rd_err = 1'b0;
        if (w_rd_ok && r_vld[read_pointer]) begin
            w_rd_opc = r_opc[read_pointer];
            w_rd_a   = r_a[read_pointer];
            w_rd_b   = r_b[read_pointer];
            w_rd_res = r_res[read_pointer];
            w_rd_vld = 1'b1;
            w_rd_err = r_err[read_pointer];
        end
`ifdef INSTR_REG_BYPASS_EN
        if (w_wr_ok && w_rd_ok && (write_pointer == read_pointer)) begin
            w_rd_opc = opcode;
            w_rd_a   = operand_a;
            w_rd_b   = operand_b;
            w_rd_res = w_res;
            w_rd_vld = 1'b1;
            w_rd_err = w_err;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_opc   <= '0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_rd_res   <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_opc <= w_rd_opc;
                r_rd_a   <= w_rd_a;
                r_rd_b   <= w_rd_b;
                r_rd_res <= w_rd_res;
                r_rd_vld <= w_rd_vld;
                r_rd_err <= w_rd_err;
            end
        end
    end

    assign rd_valid     = r_rd_valid;
    assign rd_opcode    = r_rd_opc;
    assign rd_op_a      = r_rd_a;
    assign rd_op_b      = r_rd_b;
    assign rd_result    = r_rd_res;
    assign rd_entry_vld = r_rd_vld;
    assign rd_err       = r_rd_err;
    assign wr_count     = r_wr_count;
endmodule

// File: tb/tb_instr_register_param.sv
// Bench for instr_register_param: directed scenarios then random traffic against an entry-level model.
module tb_instr_register_param;
    localparam int DEPTH = 20;
    localparam int OP_W  = 32;
    localparam int OPC_W = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clr;
    logic             load_en;
    logic [PTR_W-1:0] write_pointer;
    logic [OPC_W-1:0] opcode;
    logic [OP_W-1:0]  operand_a;
    logic [OP_W-1:0]  operand_b;
    logic             rd_en;
    logic [PTR_W-1:0] read_pointer;
    logic             rd_valid;
    logic [OPC_W-1:0] rd_opcode;
    logic [OP_W-1:0]  rd_op_a;
    logic [OP_W-1:0]  rd_op_b;
    logic [2*OP_W-1:0] rd_result;
    logic             rd_entry_vld;
    logic             rd_err;
    logic [PTR_W:0]   wr_count;

    instr_register_param #(.DEPTH(DEPTH), .OP_W(OP_W), .OPC_W(OPC_W)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load_en(load_en),
        .write_pointer(write_pointer), .opcode(opcode), .operand_a(operand_a),
        .operand_b(operand_b), .rd_en(rd_en), .read_pointer(read_pointer),
        .rd_valid(rd_valid), .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
        .rd_result(rd_result), .rd_entry_vld(rd_entry_vld), .rd_err(rd_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         vld;
        logic [3:0] opc;
        int         a;
        int         b;
        longint     res;
        bit         err;
    } ent_t;

    ent_t        mem [32];
    int          cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          e_valid;
    logic [3:0]  e_opc;
    logic [31:0] e_a, e_b;
    logic [63:0] e_res;
    bit          e_vld, e_err;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void calc(input logic [3:0] opc, input int a, input int b,
                                 output longint res, output bit err);
        res = 0;
        err = 0;
        case (opc)
            4'd0: res = 0;
            4'd1: res = a;
            4'd2: res = b;
            4'd3: res = longint'(a) + longint'(b);
            4'd4: res = longint'(a) - longint'(b);
            4'd5: res = longint'(a) * longint'(b);
            4'd6: if (b == 0) err = 1; else res = longint'(a) / longint'(b);
            4'd7: if (b == 0) err = 1; else res = longint'(a) % longint'(b);
            default: err = 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = '{0, 4'd0, 0, 0, 0, 0};
        cnt = 0;
        e_valid = 0; e_opc = '0; e_a = '0; e_b = '0; e_res = '0; e_vld = 0; e_err = 0;
    endtask

    task automatic check_all(string tag);
        chk({tag, "_valid"}, 64'(rd_valid), 64'(e_valid));
        chk({tag, "_opc"},   64'(rd_opcode), 64'(e_opc));
        chk({tag, "_a"},     64'(rd_op_a), 64'(e_a));
        chk({tag, "_b"},     64'(rd_op_b), 64'(e_b));
        chk({tag, "_res"},   rd_result, e_res);
        chk({tag, "_evld"},  64'(rd_entry_vld), 64'(e_vld));
        chk({tag, "_err"},   64'(rd_err), 64'(e_err));
        chk({tag, "_cnt"},   64'(wr_count), 64'(cnt));
    endtask

    task automatic step(string tag, bit c, bit ld, int wp, logic [3:0] opc, int a, int b,
                        bit re, int rp);
        longint nres;
        bit     nerr;
        @(negedge clk);
        clr = c; load_en = ld; write_pointer = PTR_W'(wp); opcode = opc;
        operand_a = a; operand_b = b; rd_en = re; read_pointer = PTR_W'(rp);
        calc(opc, a, b, nres, nerr);
        e_valid = re;
        if (re) begin
            if (rp < DEPTH && mem[rp].vld) begin
                e_opc = mem[rp].opc; e_a = mem[rp].a; e_b = mem[rp].b;
                e_res = mem[rp].res; e_vld = 1; e_err = mem[rp].err;
            end else begin
                e_opc = '0; e_a = '0; e_b = '0; e_res = '0; e_vld = 0; e_err = 0;
            end
`ifdef INSTR_REG_BYPASS_EN
            if (ld && wp < DEPTH && wp == rp) begin
                e_opc = opc; e_a = a; e_b = b; e_res = nres; e_vld = 1; e_err = nerr;
            end
`endif
        end
        if (c) begin
            for (int i = 0; i < 32; i++) mem[i].vld = 0;
            cnt = 0;
        end
        if (ld && wp < DEPTH) begin
            if (!mem[wp].vld) cnt++;
            mem[wp] = '{1, opc, a, b, nres, nerr};
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 0; clr = 0; load_en = 0; write_pointer = '0; opcode = '0;
        operand_a = '0; operand_b = '0; rd_en = 1; read_pointer = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        reset_n = 1; rd_en = 0;

        step("t1_rd3", 0, 0, 0, 4'd0, 0, 0, 1, 3);
        chk("t1_evld", 64'(rd_entry_vld), 64'd0);

        step("t2_w0", 0, 1, 0, 4'd3, -7, 5, 0, 0);
        step("t2_w1", 0, 1, 1, 4'd5, -3, 4, 0, 0);
        step("t2_w2", 0, 1, 2, 4'd4, 15, -15, 0, 0);
        step("t2_r0", 0, 0, 0, 4'd0, 0, 0, 1, 0);
        chk("t2_res0", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
        step("t2_r1", 0, 0, 0, 4'd0, 0, 0, 1, 1);
        chk("t2_res1", rd_result, 64'hFFFF_FFFF_FFFF_FFF4);
        step("t2_r2", 0, 0, 0, 4'd0, 0, 0, 1, 2);
        chk("t2_res2", rd_result, 64'd30);
        chk("t2_cnt", 64'(wr_count), 64'd3);

        step("t3_w8", 0, 1, 8, 4'd6, -7, 2, 0, 0);
        step("t3_w9", 0, 1, 9, 4'd7, -7, 2, 0, 0);
        step("t3_w10", 0, 1, 10, 4'd6, 9, 0, 0, 0);
        step("t3_w11", 0, 1, 11, 4'd12, 5, 3, 0, 0);
        step("t3_r8", 0, 0, 0, 4'd0, 0, 0, 1, 8);
        chk("t3_div", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);
        step("t3_r9", 0, 0, 0, 4'd0, 0, 0, 1, 9);
        chk("t3_mod", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);
        step("t3_r10", 0, 0, 0, 4'd0, 0, 0, 1, 10);
        chk("t3_div0_err", 64'(rd_err), 64'd1);
        step("t3_r11", 0, 0, 0, 4'd0, 0, 0, 1, 11);
        chk("t3_ill_err", 64'(rd_err), 64'd1);

        step("t4_w5a", 0, 1, 5, 4'd3, 1, 2, 0, 0);
        step("t4_w5b", 0, 1, 5, 4'd4, 10, 3, 0, 0);
        step("t4_r5", 0, 0, 0, 4'd0, 0, 0, 1, 5);
        chk("t4_res", rd_result, 64'd7);
        chk("t4_cnt", 64'(wr_count), 64'd8);
        step("t4_oob", 0, 1, DEPTH, 4'd3, 1, 1, 1, DEPTH);
        chk("t4_oob_cnt", 64'(wr_count), 64'd8);

        step("t5_clr", 1, 1, 4, 4'd3, 2, 3, 1, 0);
        chk("t5_preclr", 64'(rd_entry_vld), 64'd1);
        chk("t5_cnt", 64'(wr_count), 64'd1);
        step("t5_r0", 0, 0, 0, 4'd0, 0, 0, 1, 0);
        chk("t5_r0_evld", 64'(rd_entry_vld), 64'd0);
        step("t5_r4", 0, 0, 0, 4'd0, 0, 0, 1, 4);
        chk("t5_r4_evld", 64'(rd_entry_vld), 64'd1);

        step("t6_wr7", 0, 1, 7, 4'd3, 1, 1, 1, 7);
`ifdef INSTR_REG_BYPASS_EN
        chk("t6_res", rd_result, 64'd2);
        chk("t6_evld", 64'(rd_entry_vld), 64'd1);
`else
        chk("t6_res", rd_result, 64'd0);
        chk("t6_evld", 64'(rd_entry_vld), 64'd0);
`endif
        step("t6_hold", 0, 0, 0, 4'd0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int wp, rp, a, b;
            logic [3:0] opc;
            wp  = int'($urandom_range(0, DEPTH + 3));
            rp  = ($urandom_range(0, 3) == 0) ? wp : int'($urandom_range(0, DEPTH + 3));
            opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a   = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
            b   = ($urandom_range(0, 5) == 0) ? 0 :
                  ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
            step("rnd", $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, wp, opc, a, b,
                 $urandom_range(0, 3) != 0, rp);
        end

        step("t7_rd", 0, 1, 2, 4'd3, 4, 4, 1, 2);
        #1;
        reset_n = 0;
        #1;
        model_reset();
        check_all("t7_async");
        @(negedge clk);
        reset_n = 1; rd_en = 0; load_en = 0;
        step("t7_after", 0, 0, 0, 4'd0, 0, 0, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
